// File: rtl/lic_reg_write_driver.sv
// lic_reg_write_driver: two-deep token buffer driving a register's write
// and enable channels over independent VALID/CONSUMED legs.
module lic_reg_write_driver #(
  parameter int width = 8,
  parameter int cntw  = 16
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             ENQ_VALID,
  output logic             ENQ_READY,
  input  logic [width-1:0] ENQ_DATA,
  input  logic             ENQ_EN,
  output logic [width-1:0] OUT_WRITE,
  output logic             OUT_WRITE_VALID,
  input  logic             OUT_WRITE_CONSUMED,
  output logic             OUT_EN_WRITE,
  output logic             OUT_EN_WRITE_VALID,
  input  logic             OUT_EN_WRITE_CONSUMED,
  output logic [cntw-1:0]  SENT_COUNT,
  output logic             IDLE
);

  logic [width-1:0] r_head_data;
  logic             r_head_en;
  logic [width-1:0] r_tail_data;
  logic             r_tail_en;
  logic [1:0]       r_count;
  logic             r_wr_done;
  logic             r_en_done;
  logic [cntw-1:0]  r_sent;

  logic             w_nonempty;
  logic             w_enq;
  logic             w_wr_xfer;
  logic             w_en_xfer;
  logic             w_retire;
  logic [1:0]       w_count_nxt;
  logic             w_wr_done_nxt;
  logic             w_en_done_nxt;

  assign w_nonempty         = (r_count != 2'd0);
  assign ENQ_READY          = (r_count != 2'd2);
  assign IDLE               = ~w_nonempty;
  assign OUT_WRITE_VALID    = w_nonempty & ~r_wr_done;
  assign OUT_EN_WRITE_VALID = w_nonempty & ~r_en_done;
  assign OUT_WRITE          = r_head_data;
  assign OUT_EN_WRITE       = r_head_en;
  assign SENT_COUNT         = r_sent;

  assign w_enq     = ENQ_VALID & ENQ_READY;
  assign w_wr_xfer = OUT_WRITE_VALID & OUT_WRITE_CONSUMED;
  assign w_en_xfer = OUT_EN_WRITE_VALID & OUT_EN_WRITE_CONSUMED;
  assign w_retire  = w_nonempty
                   & (r_wr_done | w_wr_xfer)
                   & (r_en_done | w_en_xfer);

  // Next occupancy and per-head leg completion flags.
  always_comb begin
    w_count_nxt   = r_count;
    w_wr_done_nxt = r_wr_done | w_wr_xfer;
    w_en_done_nxt = r_en_done | w_en_xfer;
    if (w_retire) begin
      w_wr_done_nxt = 1'b0;
      w_en_done_nxt = 1'b0;
    end
    unique case ({w_retire, w_enq})
      2'b10:   w_count_nxt = r_count - 2'd1;
      2'b01:   w_count_nxt = r_count + 2'd1;
      default: w_count_nxt = r_count;
    endcase
  end

  // Control state: occupancy, done flags and retired-token counter.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_count   <= 2'd0;
      r_wr_done <= 1'b0;
      r_en_done <= 1'b0;
      r_sent    <= '0;
    end else begin
      r_count   <= w_count_nxt;
      r_wr_done <= w_wr_done_nxt;
      r_en_done <= w_en_done_nxt;
      if (w_retire) begin
        r_sent <= r_sent + 1'b1;
      end
    end
  end

  // Entry storage: head refills from tail or directly from enqueue.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      if (w_retire) begin
        if (w_enq && r_count == 2'd1) begin
          r_head_data <= ENQ_DATA;
          r_head_en   <= ENQ_EN;
        end else begin
          r_head_data <= r_tail_data;
          r_head_en   <= r_tail_en;
        end
      end else if (w_enq && r_count == 2'd0) begin
        r_head_data <= ENQ_DATA;
        r_head_en   <= ENQ_EN;
      end
      if (w_enq && !w_retire && r_count == 2'd1) begin
        r_tail_data <= ENQ_DATA;
        r_tail_en   <= ENQ_EN;
      end
    end
  end

endmodule

// File: tb/tb_lic_reg_write_driver.sv
// tb_lic_reg_write_driver: directed scenarios plus randomized traffic
// checked every cycle against a queue-based token model.
module tb_lic_reg_write_driver;

  logic       clk = 1'b0;
  logic       rst;
  logic       enq_valid;
  logic [7:0] enq_data;
  logic       enq_en;
  logic       wr_cons;
  logic       en_cons;

  logic        enq_ready, enq_ready2;
  logic [7:0]  out_wr, out_wr2;
  logic        wr_valid, wr_valid2;
  logic        out_en, out_en2;
  logic        en_valid, en_valid2;
  logic [15:0] sent;
  logic [1:0]  sent2;
  logic        idle, idle2;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic [7:0] d;
    logic       e;
  } tok_t;

  tok_t m_q[$];
  bit   m_wd;
  bit   m_ed;
  int   m_sent;

  always #5 clk = ~clk;

  lic_reg_write_driver #(.width(8), .cntw(16)) u_dut (
    .CLK(clk), .RST(rst),
    .ENQ_VALID(enq_valid), .ENQ_READY(enq_ready),
    .ENQ_DATA(enq_data), .ENQ_EN(enq_en),
    .OUT_WRITE(out_wr), .OUT_WRITE_VALID(wr_valid),
    .OUT_WRITE_CONSUMED(wr_cons),
    .OUT_EN_WRITE(out_en), .OUT_EN_WRITE_VALID(en_valid),
    .OUT_EN_WRITE_CONSUMED(en_cons),
    .SENT_COUNT(sent), .IDLE(idle)
  );

  lic_reg_write_driver #(.width(8), .cntw(2)) u_dut2 (
    .CLK(clk), .RST(rst),
    .ENQ_VALID(enq_valid), .ENQ_READY(enq_ready2),
    .ENQ_DATA(enq_data), .ENQ_EN(enq_en),
    .OUT_WRITE(out_wr2), .OUT_WRITE_VALID(wr_valid2),
    .OUT_WRITE_CONSUMED(wr_cons),
    .OUT_EN_WRITE(out_en2), .OUT_EN_WRITE_VALID(en_valid2),
    .OUT_EN_WRITE_CONSUMED(en_cons),
    .SENT_COUNT(sent2), .IDLE(idle2)
  );

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic model_check();
    bit ne;
    ne = (m_q.size() != 0);
    chk("ready", enq_ready, m_q.size() != 2);
    chk("idle", idle, !ne);
    chk("wr_valid", wr_valid, ne && !m_wd);
    chk("en_valid", en_valid, ne && !m_ed);
    chk("sent", sent, m_sent % 65536);
    chk("sent2", sent2, m_sent % 4);
    chk("idle2", idle2, !ne);
    chk("wr_valid2", wr_valid2, ne && !m_wd);
    if (ne) begin
      chk("out_wr", out_wr, m_q[0].d);
      chk("out_en", out_en, m_q[0].e);
      chk("out_wr2", out_wr2, m_q[0].d);
    end
  endtask

  task automatic model_step();
    bit ne, wx, ex, ret, acc;
    tok_t t;
    if (rst) begin
      m_q.delete();
      m_wd = 0;
      m_ed = 0;
      m_sent = 0;
      return;
    end
    ne  = (m_q.size() != 0);
    wx  = ne && !m_wd && wr_cons;
    ex  = ne && !m_ed && en_cons;
    ret = ne && (m_wd || wx) && (m_ed || ex);
    acc = enq_valid && (m_q.size() < 2);
    if (ret) begin
      void'(m_q.pop_front());
      m_wd = 0;
      m_ed = 0;
      m_sent++;
    end else begin
      if (wx) m_wd = 1;
      if (ex) m_ed = 1;
    end
    if (acc) begin
      t.d = enq_data;
      t.e = enq_en;
      m_q.push_back(t);
    end
  endtask

  task automatic cyc(input bit r, input bit v, input logic [7:0] d,
                     input bit e, input bit wc, input bit ec);
    rst       = r;
    enq_valid = v;
    enq_data  = d;
    enq_en    = e;
    wr_cons   = wc;
    en_cons   = ec;
    #1;
    model_check();
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic do_reset();
    cyc(1, 0, 8'h00, 0, 0, 0);
  endtask

  initial begin
    logic [1:0] wrap_exp [5];
    wrap_exp = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
    m_q.delete();
    m_wd = 0;
    m_ed = 0;
    m_sent = 0;
    rst = 1;
    enq_valid = 0;
    enq_data = 0;
    enq_en = 0;
    wr_cons = 0;
    en_cons = 0;
    @(negedge clk);
    // single token
    do_reset();
    do_reset();
    chk("rst_idle", idle, 1);
    chk("rst_ready", enq_ready, 1);
    chk("rst_wv", wr_valid, 0);
    cyc(0, 1, 8'h5A, 1, 1, 1);
    chk("t1_data", out_wr, 8'h5A);
    chk("t1_en", out_en, 1);
    chk("t1_wv", wr_valid, 1);
    chk("t1_ev", en_valid, 1);
    cyc(0, 0, 8'h00, 0, 1, 1);
    chk("t1_sent", sent, 1);
    chk("t1_idle", idle, 1);
    // split completion
    do_reset();
    cyc(0, 1, 8'h33, 0, 0, 0);
    cyc(0, 0, 8'h00, 0, 1, 0);
    chk("t2_wv_drop", wr_valid, 0);
    chk("t2_ev_hold", en_valid, 1);
    cyc(0, 0, 8'h00, 0, 0, 0);
    cyc(0, 0, 8'h00, 0, 0, 0);
    chk("t2_not_yet", sent, 0);
    chk("t2_data", out_wr, 8'h33);
    cyc(0, 0, 8'h00, 0, 0, 1);
    chk("t2_sent", sent, 1);
    chk("t2_idle", idle, 1);
    // backpressure
    do_reset();
    cyc(0, 1, 8'h01, 0, 0, 0);
    cyc(0, 1, 8'h02, 0, 0, 0);
    chk("t3_full", enq_ready, 0);
    cyc(0, 1, 8'h03, 0, 0, 0);
    chk("t3_head", out_wr, 8'h01);
    cyc(0, 1, 8'h03, 0, 1, 1);
    chk("t3_second", out_wr, 8'h02);
    cyc(0, 1, 8'h03, 0, 1, 1);
    chk("t3_third", out_wr, 8'h03);
    cyc(0, 0, 8'h00, 0, 1, 1);
    chk("t3_sent", sent, 3);
    chk("t3_idle", idle, 1);
    // enqueue on retire at count==1
    do_reset();
    cyc(0, 1, 8'h10, 1, 0, 0);
    cyc(0, 1, 8'h20, 0, 1, 1);
    chk("t4_head", out_wr, 8'h20);
    chk("t4_wv", wr_valid, 1);
    chk("t4_ev", en_valid, 1);
    chk("t4_one", enq_ready && !idle, 1);
    // reset mid-token
    do_reset();
    cyc(0, 1, 8'hA1, 1, 0, 0);
    cyc(0, 1, 8'hA2, 0, 0, 0);
    cyc(0, 0, 8'h00, 0, 1, 0);
    chk("t5_wd", wr_valid, 0);
    do_reset();
    chk("t5_wv", wr_valid, 0);
    chk("t5_ev", en_valid, 0);
    chk("t5_idle", idle, 1);
    chk("t5_sent", sent, 0);
    chk("t5_ready", enq_ready, 1);
    cyc(0, 1, 8'h77, 1, 0, 0);
    chk("t5_data", out_wr, 8'h77);
    chk("t5_both", wr_valid && en_valid, 1);
    // counter wrap on the 2-bit instance
    do_reset();
    cyc(0, 1, 8'h40, 0, 1, 1);
    for (int i = 0; i < 5; i++) begin
      cyc(0, 1, 8'h41 + 8'(i), 1, 1, 1);
      chk("wrap", sent2, wrap_exp[i]);
    end
    // randomized traffic
    do_reset();
    for (int i = 0; i < 4000; i++) begin
      cyc($urandom_range(0, 99) == 0,
          $urandom_range(0, 2) != 0,
          8'($urandom),
          1'($urandom),
          $urandom_range(0, 2) != 0,
          $urandom_range(0, 2) != 0);
    end
    cyc(0, 0, 8'h00, 0, 1, 1);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
